// File: rtl/sample_recorder_snare.sv
// sample_recorder_snare: captures MAXCOUNT+1 consecutive audio samples into the
// snare sample RAM (addresses 0..MAXCOUNT) once armed and triggered.
// Optional feature macro: SNARE_REC_THRESH_EN (magnitude trigger in ARMED).
// Ports:
//   clk, reset         clock, async active-high reset
//   arm                one-cycle capture request (accepted only when idle)
//   sample_valid       sample_in carries a new sample this cycle
//   sample_in          signed DATA_W-bit audio sample
//   wr_en/addr/data    registered RAM write port
//   busy               high while armed or recording
//   done               one-cycle pulse with the final write
module sample_recorder_snare #(
    parameter logic [14:0]       MAXCOUNT  = 15'd16481,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] THRESHOLD = 8'd16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              arm,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_in,
    output logic              wr_en,
    output logic [14:0]       wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        RECORD = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [14:0]       cnt_q, cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [14:0]       wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              trig;

`ifdef SNARE_REC_THRESH_EN
    // One extra bit so |most negative| fits without overflow.
    logic [DATA_W:0] ext;
    logic [DATA_W:0] mag;

    assign ext  = {sample_in[DATA_W-1], sample_in};
    assign mag  = ext[DATA_W] ? (~ext + {{DATA_W{1'b0}}, 1'b1}) : ext;
    assign trig = (mag >= {1'b0, THRESHOLD});
`else
    logic unused_thresh;

    assign unused_thresh = ^THRESHOLD;
    assign trig          = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d = ARMED;
                    cnt_d   = '0;
                end
            end
            ARMED: begin
                if (sample_valid && trig) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = '0;
                    wr_data_d = sample_in;
                    if (MAXCOUNT == 15'd0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = 15'd1;
                        state_d = RECORD;
                    end
                end
            end
            RECORD: begin
                if (sample_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q;
                    wr_data_d = sample_in;
                    // Counter holds at MAXCOUNT; DONE ends the capture.
                    if (cnt_q == MAXCOUNT) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + 15'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    // The final write lands as the state enters DONE, so done and the
    // last strobe share a cycle and busy falls with them.
    assign busy    = (state_q == ARMED) || (state_q == RECORD);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_sample_recorder_snare.sv
// tb_sample_recorder_snare: scoreboard bench for sample_recorder_snare.
// Works with or without SNARE_REC_THRESH_EN defined.
module tb_sample_recorder_snare;

    localparam int MAXC = 16481;

    logic        clk = 1'b0;
    logic        reset;
    logic        arm;
    logic        sample_valid;
    logic [7:0]  sample_in;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;

    sample_recorder_snare dut (
        .clk          (clk),
        .reset        (reset),
        .arm          (arm),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] a;
        logic [7:0]  d;
        logic        last;
    } exp_t;

    exp_t       q[$];
    exp_t       e_mon;
    int         total = 0;
    int         bad = 0;
    int         strobes = 0;
    int         dones = 0;
    int         m_state = 0;
    int         m_cnt = 0;
    logic [7:0] first_d = 8'h00;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit trig(logic [7:0] d);
`ifdef SNARE_REC_THRESH_EN
        int v;
        v = int'($signed(d));
        if (v < 0) v = -v;
        return v >= 16;
`else
        return d === d;
`endif
    endfunction

    task automatic step(bit a, bit v, logic [7:0] d);
        exp_t e;
        arm          = a;
        sample_valid = v;
        sample_in    = d;
        case (m_state)
            0: begin
                if (a) begin
                    m_state = 1;
                    m_cnt   = 0;
                end
            end
            1: begin
                if (v && trig(d)) begin
                    e.a    = 15'd0;
                    e.d    = d;
                    e.last = 1'b0;
                    q.push_back(e);
                    m_cnt   = 1;
                    m_state = 2;
                end
            end
            2: begin
                if (v) begin
                    e.a    = m_cnt[14:0];
                    e.d    = d;
                    e.last = (m_cnt == MAXC);
                    q.push_back(e);
                    if (e.last) m_state = 3;
                    else m_cnt++;
                end
            end
            default: m_state = 0;
        endcase
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (wr_en) begin
                strobes++;
                if (wr_addr == 15'd0) first_d = wr_data;
                if (q.size() == 0) begin
                    check("spurious_wr", wr_en, 1'b0);
                end else begin
                    e_mon = q.pop_front();
                    check("wr_addr", wr_addr, e_mon.a);
                    check("wr_data", wr_data, e_mon.d);
                    check("done_with_last", done, e_mon.last);
                end
            end else begin
                check("done_no_wr", done, 1'b0);
            end
            if (done) begin
                dones++;
                check("busy_at_done", busy, 1'b0);
            end
        end
    end

    logic [7:0] seq [6];
    int         i;

    task automatic check_outs_zero(string tag);
        check({tag, "_wr_en"}, wr_en, 1'b0);
        check({tag, "_wr_addr"}, wr_addr, 15'd0);
        check({tag, "_wr_data"}, wr_data, 8'd0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
    endtask

    task automatic finish_capture(string tag);
        int g;
        g = 0;
        while (m_state != 0 && g < 40000) begin
            step(1'b0, 1'b1, 8'(i));
            i++;
            g++;
        end
        repeat (3) step(1'b0, 1'b0, 8'h00);
        check({tag, "_strobes"}, strobes, MAXC + 1);
        check({tag, "_dones"}, dones, 1);
        check({tag, "_queue"}, q.size(), 0);
        check({tag, "_busy_end"}, busy, 1'b0);
    endtask

    initial begin
        seq = '{8'h00, 8'h03, 8'hF6, 8'h0F, 8'hF0, 8'h28};
        reset        = 1'b1;
        arm          = 1'b0;
        sample_valid = 1'b0;
        sample_in    = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_outs_zero("rst");
        reset = 1'b0;
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h55);
        step(1'b0, 1'b1, 8'hAA);
        check("idle_busy", busy, 1'b0);

        // Capture aborted by reset at address 100.
        step(1'b1, 1'b0, 8'h00);
        check("a_busy_arm", busy, 1'b1);
        foreach (seq[k]) step(1'b0, 1'b1, seq[k]);
        i = 0;
        while (m_cnt < 100 && i < 1000) begin
            step(1'b0, 1'b1, 8'(i));
            i++;
        end
        reset = 1'b1;
        #1;
        check_outs_zero("abort_now");
        @(posedge clk);
        #1;
        check_outs_zero("abort_next");
        q.delete();
        m_state = 0;
        m_cnt   = 0;
        reset   = 1'b0;
        step(1'b0, 1'b1, 8'h11);
        step(1'b0, 1'b1, 8'h22);
        check("abort_idle_busy", busy, 1'b0);
        check("abort_no_done", dones, 0);

        // Most negative sample triggers; gappy valid and stray arm pulses.
        strobes = 0;
        dones   = 0;
        first_d = 8'h00;
        step(1'b1, 1'b0, 8'h00);
        check("b_busy_arm", busy, 1'b1);
        step(1'b0, 1'b1, 8'h80);
        for (int k = 0; k < 300; k++) begin
            step((k % 7) == 3, (k % 2) == 0, 8'(k + 7));
        end
        i = 500;
        finish_capture("b");
        check("b_first", first_d, 8'h80);

        // Threshold sequence then a continuous ramp.
        strobes = 0;
        dones   = 0;
        first_d = 8'hFF;
        step(1'b1, 1'b0, 8'h00);
        foreach (seq[k]) step(1'b0, 1'b1, seq[k]);
        step(1'b1, 1'b1, 8'h5A);
        i = 0;
        finish_capture("c");
`ifdef SNARE_REC_THRESH_EN
        check("c_first", first_d, 8'hF0);
`else
        check("c_first", first_d, 8'h00);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sample_recorder_snare.md
# sample_recorder_snare

Capture-side counterpart of the snare playback counter: records a fixed-length snare sample into the sample RAM that playback later reads. The block takes a stream of signed audio samples. Once armed, it waits for a trigger condition, then writes exactly MAXCOUNT+1 consecutive samples to RAM addresses 0..MAXCOUNT and pulses `done`. The block sits between the audio input front end and the write port of the snare sample RAM.

## Interface
Parameters:
- `MAXCOUNT`, 15'd16481, last RAM address written; the recording length is MAXCOUNT+1 samples.
- `DATA_W`, 8, sample width in bits, two's complement.
- `THRESHOLD`, 8'd16, trigger magnitude, unsigned, DATA_W bits wide.

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `arm`  input  1  single-cycle request to start a capture.
- `sample_valid`  input  1  `sample_in` holds a new sample this cycle.
- `sample_in`  input  DATA_W  signed audio sample.
- `wr_en`  output  1  RAM write strobe, registered.
- `wr_addr`  output  15  RAM write address, registered.
- `wr_data`  output  DATA_W  RAM write data, registered.
- `busy`  output  1  high in ARMED and RECORD.
- `done`  output  1  one-cycle pulse when capture completes.

## Operation
- States: IDLE, ARMED, RECORD, DONE.
- Reset (async, any state): state=IDLE; `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0; internal address counter=0.
- **IDLE**
  - `arm`=1 → ARMED; the address counter clears to 0.
  - `sample_valid` is ignored.
- **ARMED**
  - On `sample_valid`=1 with the trigger true → the sample is written at address 0, counter=1, state → RECORD.
  - If the trigger is false, the sample is discarded.
- **RECORD**
  - Each `sample_valid`=1 writes `sample_in` at the current counter value, then the counter increments.
  - The write at address MAXCOUNT → DONE.
  - Gaps in `sample_valid` stall the block with no write.
- **DONE**
  - Lasts exactly one cycle; `done`=1, then → IDLE.
- `arm` is ignored in ARMED, RECORD and DONE. A re-arm is accepted only from IDLE.
- Trigger magnitude: |`sample_in`| is computed in DATA_W+1 bits, so the most negative value gives magnitude 2^(DATA_W-1) with no overflow. The trigger is true when magnitude ≥ `THRESHOLD`.
- Address arithmetic:
  - The counter is 15 bits and never exceeds MAXCOUNT.
  - There is no wrap-around; the block never writes beyond MAXCOUNT.
- Exactly MAXCOUNT+1 write strobes occur per completed capture.
- Reset asserted mid-RECORD aborts the capture: no further writes, no `done`. RAM contents already written are left as is.

## Timing
- Write latency is one cycle: a sample accepted at edge N appears as `wr_en`=1 with `wr_addr`/`wr_data` valid in the cycle after edge N. `wr_en` is 0 otherwise.
- The final write (`wr_addr`=MAXCOUNT) and `done`=1 are asserted in the same cycle. `busy` drops in that same cycle.
- `busy` rises the cycle after `arm` is sampled in IDLE.
- Back-to-back `sample_valid` sustains one write per cycle.

## Configuration
- Macro `SNARE_REC_THRESH_EN`.
- Defined: ARMED waits for the magnitude trigger, as described above.
- Undefined:
  - The trigger is constant true: the first `sample_valid` in ARMED starts the recording.
  - `THRESHOLD` is unused, and no magnitude logic is synthesized.

## Test plan
- Reset mid-RECORD at address 100 → all outputs 0 next cycle, state IDLE, no `done`. A subsequent `arm` plus a full capture writes from address 0.
- With macro defined, THRESHOLD=16: arm, then feed 3, -10, 15, -16, 40 → first write is addr 0 = -16 (8'hF0); addr 1 = 40.
- With macro defined: feed -128 after arm → triggers; addr 0 data 8'h80.
- Continuous `sample_valid` ramp → writes to addresses 0..16481 on consecutive cycles, 16482 strobes total. `done`=1 coincides with addr 16481; no write follows.
- `sample_valid` toggled 1/0 during RECORD and `arm` pulsed mid-capture → addresses stay contiguous, `arm` has no effect, one write per valid.
- Macro undefined: arm, then feed 0 → capture starts with addr 0 = 0.
